rom_access_arbiter: RTL
=======================

Name: rom_access_arbiter

Overview:
- Shares the single-port, asynchronous-read program ROM between two requesters: port 0 (instruction fetch) and port 1 (data load from the ROM constant region).
- Translates byte addresses to ROM word indices and range/alignment-checks them.
- Arbitrates with fixed priority plus an anti-starvation override, and registers the read data into a one-cycle-latency response per port.
- Sits between the core's fetch/load-store units and the ROM instance.

Parameters:
- DATA_WIDTH, 32, ROM word width.
- ADDR_WIDTH, 10, ROM word-index width; the ROM holds 2**ADDR_WIDTH words.
- BASE_ADDR, 32'h0040_0000, byte address that maps to ROM word 0.
- MAX_WAIT, 4, consecutive denied cycles on port 1 before it is forced to win.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  port 0 request.
- req0_addr  input  32  port 0 byte address.
- req0_ready  output  1  port 0 granted this cycle.
- resp0_valid  output  1  port 0 response strobe.
- resp0_data  output  DATA_WIDTH  port 0 read data.
- resp0_err  output  1  port 0 address fault.
- req1_valid, req1_addr, req1_ready, resp1_valid, resp1_data, resp1_err: same as port 0, for port 1.
- rom_addr  output  ADDR_WIDTH  word index driven to the ROM A input.
- rom_rd  input  DATA_WIDTH  ROM RD output (combinational).

Behaviour:
- Reset: clk and rst as already decided (one clock; synchronous, active-high reset). While rst is high at a clock edge:
  - all resp*_valid, resp*_err and resp*_data clear to 0;
  - the wait counter clears to 0;
  - the state register goes to IDLE.
- req*_ready is combinational and is 0 while rst=1.
- Acceptance: a request is accepted when req_valid && req_ready in the same cycle.
  - The requester holds valid and addr stable until accepted.
  - No backpressure on responses.
- Arbitration: each cycle exactly one port may be granted.
  - Default: port 0 wins whenever req0_valid=1.
  - Override: if wait_cnt == MAX_WAIT and req1_valid=1, port 1 wins even when port 0 is requesting.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) on each cycle with req1_valid=1 and port 1 not granted.
  - Clears on a port 1 grant, or on any cycle with req1_valid=0.
- State machine: IDLE, GNT0, GNT1. The state records the port granted in the previous cycle and selects which response is emitted this cycle.
  - IDLE → GNT0 when port 0 is granted.
  - IDLE → GNT1 when port 1 is granted.
  - IDLE → IDLE when there is no grant.
  - The same transitions apply from GNT0 and GNT1, so back-to-back grants are allowed (throughput of one access per cycle).
- rom_addr = (granted_addr - BASE_ADDR) >> 2, truncated to ADDR_WIDTH. It is driven to 0 when nothing is granted.
- Fault: the granted address faults if either holds:
  - granted_addr[1:0] != 0;
  - (granted_addr - BASE_ADDR) is >= 4*2**ADDR_WIDTH, unsigned. An address below BASE_ADDR wraps negative and therefore faults.
- Latency: exactly one cycle. At the edge after acceptance, the winning port's registers load:
  - resp_valid = 1;
  - resp_data = rom_rd, or 0 on fault;
  - resp_err = fault flag.
- The losing port's resp_valid is 0. A response register holds its data until the next response for that port; only resp_valid pulses for one cycle.
- Simultaneous requests: port 0 is served first. Port 1 is served no later than MAX_WAIT+1 cycles after it begins requesting.
- Reset mid-operation: any accepted-but-unanswered request is dropped, and no response is emitted on the following cycle.

Optional Feature:
- Macro: ROM_ACCESS_STATS_EN.
- When defined, two output ports are added, plus an internal counter:
  - gnt0_cnt and gnt1_cnt, each 32 bits: per-port grant counters that wrap modulo 2**32 and clear on rst.
  - stall_cnt: internal 32-bit count of cycles in which any valid request went ungranted.
- When undefined, the extra ports, counters and logic are absent, and the behaviour above is unchanged.

Decomposition:
- Package rom_arb_pkg holds:
  - typedef enum for the IDLE/GNT0/GNT1 states;
  - port index localparams PORT_IF=0 and PORT_LD=1;
  - the default BASE_ADDR constant.
- Sub-module rom_addr_xlate (combinational): byte address to word index, plus the fault flag. It is instantiated once, on the granted address.

Test Plan:
- After reset, req0 only, addr 0x0040_0008 (rom[2]=0x00500093) → req0_ready=1; next cycle resp0_valid=1, resp0_data=0x00500093, resp0_err=0.
- req0 and req1 held continuously, MAX_WAIT=4 → port 1 is granted on the 5th cycle of requesting; port 0 on all others; wait_cnt returns to 0.
- Faults on port 1:
  - req1 addr 0x0040_0002 → resp1_err=1, resp1_data=0;
  - req1 addr 0x0040_1000 (ADDR_WIDTH=10) → resp1_err=1;
  - req1 addr 0x003F_FFFC → resp1_err=1.
- Back-to-back port 0 requests at 0x0040_0000 then 0x0040_0FFC → responses on consecutive cycles returning rom[0] and rom[1023].
- Accept req1, then assert rst for one cycle → no resp1_valid after rst; all outputs are 0; the state is IDLE.
- With ROM_ACCESS_STATS_EN, 10 port 0 grants and 3 port 1 grants → gnt0_cnt=10, gnt1_cnt=3.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the ROM access arbiter.
//   arb_state_e   : IDLE / GNT0 / GNT1, the port granted in the previous cycle
//   PORT_IF/LD    : requester indices (instruction fetch, constant load)
//   DEF_BASE_ADDR : default byte address of ROM word 0
package rom_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_e;

   localparam int unsigned PORT_IF = 0;
   localparam int unsigned PORT_LD = 1;

   localparam logic [31:0] DEF_BASE_ADDR = 32'h0040_0000;

endpackage

// File: rtl/rom_addr_xlate.sv
// Byte address to ROM word index translation with range/alignment fault.
//   i_addr  : byte address of the granted request
//   o_index : (i_addr - BASE_ADDR) >> 2, truncated to ADDR_WIDTH
//   o_fault : misaligned, or offset outside the 4*2**ADDR_WIDTH byte window
module rom_addr_xlate
   import rom_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR
) (
   input  logic [31:0]           i_addr,
   output logic [ADDR_WIDTH-1:0] o_index,
   output logic                  o_fault
);

   // Byte window size held in 64 bits so large ADDR_WIDTH values cannot overflow.
   localparam logic [63:0] LIMIT = 64'd4 << ADDR_WIDTH;

   logic [31:0] w_off;

   // Addresses below BASE_ADDR wrap to a huge offset and land in the fault range.
   assign w_off   = i_addr - BASE_ADDR;
   assign o_index = w_off[ADDR_WIDTH+1:2];
   assign o_fault = (i_addr[1:0] != 2'b00) || ({32'd0, w_off} >= LIMIT);

endmodule

// File: rtl/rom_access_arbiter.sv
// Two-port arbiter in front of the single-port asynchronous-read program ROM.
//   clk, rst                 : clock, synchronous active-high reset
//   req0_* / resp0_*         : instruction-fetch port (default priority)
//   req1_* / resp1_*         : constant-load port (anti-starvation override)
//   req*_ready               : combinational grant for this cycle
//   resp*_valid/_data/_err   : one-cycle-latency registered response
//   rom_addr / rom_rd        : ROM word index out, combinational read data in
// Optional build macro ROM_ACCESS_STATS_EN adds gnt0_cnt / gnt1_cnt outputs
// and an internal stall counter.
module rom_access_arbiter
   import rom_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
   parameter int unsigned MAX_WAIT   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   input  logic [31:0]           req0_addr,
   output logic                  req0_ready,
   output logic                  resp0_valid,
   output logic [DATA_WIDTH-1:0] resp0_data,
   output logic                  resp0_err,
   input  logic                  req1_valid,
   input  logic [31:0]           req1_addr,
   output logic                  req1_ready,
   output logic                  resp1_valid,
   output logic [DATA_WIDTH-1:0] resp1_data,
   output logic                  resp1_err,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_rd
`ifdef ROM_ACCESS_STATS_EN
   ,
   output logic [31:0]           gnt0_cnt,
   output logic [31:0]           gnt1_cnt
`endif
);

   localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

   logic [1:0]            w_req;
   logic [1:0]            w_gnt;
   logic                  w_force_ld;
   logic [31:0]           w_gnt_addr;
   logic [ADDR_WIDTH-1:0] w_index;
   logic                  w_fault;
   logic [DATA_WIDTH-1:0] w_rd_data;
   logic [WAIT_W-1:0]     r_wait_cnt;
   logic [WAIT_W-1:0]     w_wait_nxt;
   arb_state_e            r_state;
   arb_state_e            w_state_nxt;
   logic [DATA_WIDTH-1:0] r_resp0_data;
   logic [DATA_WIDTH-1:0] r_resp1_data;
   logic                  r_resp0_err;
   logic                  r_resp1_err;

   assign w_req[PORT_IF] = req0_valid;
   assign w_req[PORT_LD] = req1_valid;

   // Port 1 has waited long enough and must win over port 0.
   assign w_force_ld = w_req[PORT_LD] && (r_wait_cnt == WAIT_W'(MAX_WAIT));

   // Grant: fixed priority to port 0 unless the starvation override fires.
   always_comb begin
      w_gnt = 2'b00;
      if (!rst) begin
         if (w_force_ld) begin
            w_gnt[PORT_LD] = 1'b1;
         end else if (w_req[PORT_IF]) begin
            w_gnt[PORT_IF] = 1'b1;
         end else if (w_req[PORT_LD]) begin
            w_gnt[PORT_LD] = 1'b1;
         end
      end
   end

   assign req0_ready = w_gnt[PORT_IF];
   assign req1_ready = w_gnt[PORT_LD];
   assign w_gnt_addr = w_gnt[PORT_LD] ? req1_addr : req0_addr;

   rom_addr_xlate #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .BASE_ADDR  (BASE_ADDR)
   ) u_xlate (
      .i_addr  (w_gnt_addr),
      .o_index (w_index),
      .o_fault (w_fault)
   );

   assign rom_addr  = (|w_gnt) ? w_index : '0;
   assign w_rd_data = w_fault ? '0 : rom_rd;

   // Wait counter: counts consecutive denied port 1 cycles, saturating.
   always_comb begin
      w_wait_nxt = '0;
      if (w_req[PORT_LD] && !w_gnt[PORT_LD]) begin
         w_wait_nxt = (r_wait_cnt == WAIT_W'(MAX_WAIT)) ? r_wait_cnt
                                                        : r_wait_cnt + WAIT_W'(1);
      end
   end

   // Next state records which port is granted now, i.e. which answers next cycle.
   always_comb begin
      w_state_nxt = IDLE;
      if (w_gnt[PORT_IF]) begin
         w_state_nxt = GNT0;
      end else if (w_gnt[PORT_LD]) begin
         w_state_nxt = GNT1;
      end
   end

   // State, wait counter and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_wait_cnt   <= '0;
         r_resp0_data <= '0;
         r_resp0_err  <= 1'b0;
         r_resp1_data <= '0;
         r_resp1_err  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
         if (w_gnt[PORT_IF]) begin
            r_resp0_data <= w_rd_data;
            r_resp0_err  <= w_fault;
         end
         if (w_gnt[PORT_LD]) begin
            r_resp1_data <= w_rd_data;
            r_resp1_err  <= w_fault;
         end
      end
   end

   assign resp0_valid = (r_state == GNT0);
   assign resp1_valid = (r_state == GNT1);
   assign resp0_data  = r_resp0_data;
   assign resp0_err   = r_resp0_err;
   assign resp1_data  = r_resp1_data;
   assign resp1_err   = r_resp1_err;

`ifdef ROM_ACCESS_STATS_EN
   logic [31:0] r_gnt0_cnt;
   logic [31:0] r_gnt1_cnt;
   logic [31:0] r_stall_cnt;
   logic        w_stall;

   assign w_stall = (req0_valid && !w_gnt[PORT_IF]) || (req1_valid && !w_gnt[PORT_LD]);

   // Grant and stall statistics, wrapping modulo 2**32.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_gnt0_cnt  <= '0;
         r_gnt1_cnt  <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_gnt[PORT_IF]) r_gnt0_cnt <= r_gnt0_cnt + 32'd1;
         if (w_gnt[PORT_LD]) r_gnt1_cnt <= r_gnt1_cnt + 32'd1;
         if (w_stall)        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign gnt0_cnt = r_gnt0_cnt;
   assign gnt1_cnt = r_gnt1_cnt;
`else
   // Statistics disabled: no counters are built.
`endif

endmodule
